// File: rtl/quad_encoder_scheduler_pkg.sv
// Shared types and constants for the quadrature-encoder snapshot sequencer:
// FSM state encoding, host register word addresses and CTRL/STATUS bit positions.
package quad_encoder_scheduler_pkg;

    localparam int unsigned DATA_W = 32;

    localparam int unsigned REG_CTRL      = 0;
    localparam int unsigned REG_PERIOD    = 1;
    localparam int unsigned REG_STATUS    = 2;
    localparam int unsigned REG_SEQ       = 3;
    localparam int unsigned REG_SNAP_BASE = 8;

    localparam int unsigned CTRL_EN_BIT   = 0;
    localparam int unsigned CTRL_TRIG_BIT = 1;
    localparam int unsigned CTRL_IE_BIT   = 2;

    localparam int unsigned STAT_BUSY_BIT    = 0;
    localparam int unsigned STAT_READY_BIT   = 1;
    localparam int unsigned STAT_OVERRUN_BIT = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        WAIT   = 2'd2,
        COMMIT = 2'd3
    } state_t;

    // Channel-select width, kept at least one bit so a single-channel build stays legal.
    function automatic int unsigned chan_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/quad_encoder_scheduler_timer.sv
// Free-running period counter: counts while enabled with a non-zero period and
// pulses o_fire_c for one cycle when the count reaches period-1.
module quad_encoder_scheduler_timer #(
    parameter int unsigned pW = 32
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_en,
    input  logic [pW-1:0] i_period,
    input  logic          i_restart,
    output logic          o_fire_c
);

    logic [pW-1:0] r_count;
    logic          w_active;
    logic          w_wrap;

    always_comb begin
        w_active = i_en && (i_period != '0);
        w_wrap   = (r_count == (i_period - pW'(1)));
        // A period write restarts the count and swallows a coincident fire.
        o_fire_c = w_active && w_wrap && !i_restart;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_restart || !w_active || w_wrap) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + pW'(1);
        end
    end

endmodule

// File: rtl/quad_encoder_scheduler.sv
// Round-robin encoder snapshot sequencer with atomic POS/DELTA commit and host register bank.
// Optional snapshot-ready interrupt (oIRQ, CTRL.IE) enabled by QUAD_ENCODER_SCHEDULER_IRQ_EN.
module quad_encoder_scheduler
    import quad_encoder_scheduler_pkg::*;
#(
    parameter int unsigned pENCODERS          = 2,
    parameter int unsigned pENCODER_PRECISION = 32,
    parameter int unsigned pADDR_W            = $clog2(8 + 2 * pENCODERS),
    parameter int unsigned pCH_W              = chan_w(pENCODERS)
) (
    input  logic                          iCLK,
    input  logic                          iRESET_N,
    input  logic [pADDR_W-1:0]            iAVL_ADDRESS,
    input  logic                          iAVL_READ,
    input  logic                          iAVL_WRITE,
    input  logic [DATA_W-1:0]             iAVL_WRITE_DATA,
    output logic [DATA_W-1:0]             oAVL_READ_DATA,
    output logic [pCH_W-1:0]              oENC_ADDRESS,
    output logic                          oENC_READ,
    input  logic [pENCODER_PRECISION-1:0] iENC_READ_DATA
`ifdef QUAD_ENCODER_SCHEDULER_IRQ_EN
    ,
    output logic                          oIRQ
`endif
);

    state_t              r_state;
    logic [pCH_W-1:0]    r_chan;
    logic                r_enc_read;
    logic [pCH_W-1:0]    r_enc_addr;
    logic [DATA_W-1:0]   r_pending [pENCODERS];
    logic [DATA_W-1:0]   r_pos     [pENCODERS];
    logic [DATA_W-1:0]   r_delta   [pENCODERS];
    logic [DATA_W-1:0]   r_seq;
    logic [DATA_W-1:0]   r_period;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_en;
    logic                r_ready;
    logic                r_overrun;
    logic                r_first;

    logic                w_wr_ctrl;
    logic                w_wr_period;
    logic                w_wr_status;
    logic                w_fire_c;
    logic                w_trig;
    logic                w_drop;
    logic                w_commit;
    logic                w_busy;
    logic                w_last;
    logic                w_en_rise;
    logic                w_ready_nxt;
    logic                w_ie_rd;
    logic [DATA_W-1:0]   w_rd_mux;

    // Host write decode and trigger arbitration; timer fire and TRIG merge into one trigger.
    always_comb begin
        w_wr_ctrl   = iAVL_WRITE && (iAVL_ADDRESS == pADDR_W'(REG_CTRL));
        w_wr_period = iAVL_WRITE && (iAVL_ADDRESS == pADDR_W'(REG_PERIOD));
        w_wr_status = iAVL_WRITE && (iAVL_ADDRESS == pADDR_W'(REG_STATUS));
        w_trig      = w_fire_c || (w_wr_ctrl && iAVL_WRITE_DATA[CTRL_TRIG_BIT]);
        w_busy      = (r_state != IDLE);
        w_drop      = w_trig && w_busy;
        w_commit    = (r_state == COMMIT);
        w_last      = (r_chan == pCH_W'(pENCODERS - 1));
        w_en_rise   = w_wr_ctrl && iAVL_WRITE_DATA[CTRL_EN_BIT] && !r_en;
        w_ready_nxt = w_commit ? 1'b1
                    : (w_wr_status && iAVL_WRITE_DATA[STAT_READY_BIT]) ? 1'b0
                    : r_ready;
    end

    quad_encoder_scheduler_timer #(
        .pW (DATA_W)
    ) u_timer (
        .i_clk     (iCLK),
        .i_rst_n   (iRESET_N),
        .i_en      (r_en),
        .i_period  (r_period),
        .i_restart (w_wr_period),
        .o_fire_c  (w_fire_c)
    );

    // Control and sticky status registers; hardware set wins over a same-cycle clear.
    always_ff @(posedge iCLK or negedge iRESET_N) begin
        if (!iRESET_N) begin
            r_en      <= 1'b0;
            r_period  <= '0;
            r_ready   <= 1'b0;
            r_overrun <= 1'b0;
            r_first   <= 1'b1;
        end else begin
            if (w_wr_ctrl) begin
                r_en <= iAVL_WRITE_DATA[CTRL_EN_BIT];
            end
            if (w_wr_period) begin
                r_period <= iAVL_WRITE_DATA;
            end
            r_ready <= w_ready_nxt;
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (w_wr_status && iAVL_WRITE_DATA[STAT_OVERRUN_BIT]) begin
                r_overrun <= 1'b0;
            end
            if (w_en_rise) begin
                r_first <= 1'b1;
            end else if (w_commit) begin
                r_first <= 1'b0;
            end
        end
    end

`ifdef QUAD_ENCODER_SCHEDULER_IRQ_EN
    logic r_ie;
    logic r_irq;
    logic w_ie_nxt;

    always_comb begin
        w_ie_nxt = w_wr_ctrl ? iAVL_WRITE_DATA[CTRL_IE_BIT] : r_ie;
        w_ie_rd  = r_ie;
    end

    always_ff @(posedge iCLK or negedge iRESET_N) begin
        if (!iRESET_N) begin
            r_ie  <= 1'b0;
            r_irq <= 1'b0;
        end else begin
            r_ie  <= w_ie_nxt;
            r_irq <= w_ready_nxt && w_ie_nxt;
        end
    end

    assign oIRQ = r_irq;
`else
    always_comb begin
        w_ie_rd = 1'b0;
    end
`endif

    // Sequencer: one ISSUE/WAIT pair per channel, then a single COMMIT cycle.
    always_ff @(posedge iCLK or negedge iRESET_N) begin
        if (!iRESET_N) begin
            r_state    <= IDLE;
            r_chan     <= '0;
            r_enc_read <= 1'b0;
            r_enc_addr <= '0;
            for (int c = 0; c < pENCODERS; c++) begin
                r_pending[c] <= '0;
            end
        end else begin
            r_enc_read <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_trig) begin
                        r_state    <= ISSUE;
                        r_chan     <= '0;
                        r_enc_read <= 1'b1;
                        r_enc_addr <= '0;
                    end
                end
                ISSUE: begin
                    r_state <= WAIT;
                end
                WAIT: begin
                    r_pending[r_chan] <= DATA_W'(iENC_READ_DATA);
                    if (w_last) begin
                        r_state <= COMMIT;
                    end else begin
                        r_state    <= ISSUE;
                        r_chan     <= r_chan + pCH_W'(1);
                        r_enc_read <= 1'b1;
                        r_enc_addr <= r_chan + pCH_W'(1);
                    end
                end
                COMMIT: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Atomic snapshot commit; the first sample after reset or EN rise has no reference.
    always_ff @(posedge iCLK or negedge iRESET_N) begin
        if (!iRESET_N) begin
            r_seq <= '0;
            for (int c = 0; c < pENCODERS; c++) begin
                r_pos[c]   <= '0;
                r_delta[c] <= '0;
            end
        end else if (w_commit) begin
            r_seq <= r_seq + DATA_W'(1);
            for (int c = 0; c < pENCODERS; c++) begin
                r_pos[c]   <= r_pending[c];
                r_delta[c] <= r_first ? '0 : (r_pending[c] - r_pos[c]);
            end
        end
    end

    always_comb begin
        w_rd_mux = '0;
        if (iAVL_ADDRESS == pADDR_W'(REG_CTRL)) begin
            w_rd_mux = DATA_W'({w_ie_rd, 1'b0, r_en});
        end else if (iAVL_ADDRESS == pADDR_W'(REG_PERIOD)) begin
            w_rd_mux = r_period;
        end else if (iAVL_ADDRESS == pADDR_W'(REG_STATUS)) begin
            w_rd_mux = DATA_W'({r_overrun, r_ready, w_busy});
        end else if (iAVL_ADDRESS == pADDR_W'(REG_SEQ)) begin
            w_rd_mux = r_seq;
        end
        for (int c = 0; c < pENCODERS; c++) begin
            if (iAVL_ADDRESS == pADDR_W'(REG_SNAP_BASE + 2 * c)) begin
                w_rd_mux = r_pos[c];
            end
            if (iAVL_ADDRESS == pADDR_W'(REG_SNAP_BASE + 2 * c + 1)) begin
                w_rd_mux = r_delta[c];
            end
        end
    end

    // Registered host read port: returns the value from before the sampling edge.
    always_ff @(posedge iCLK or negedge iRESET_N) begin
        if (!iRESET_N) begin
            r_rdata <= '0;
        end else if (iAVL_READ) begin
            r_rdata <= w_rd_mux;
        end
    end

    assign oAVL_READ_DATA = r_rdata;
    assign oENC_READ      = r_enc_read;
    assign oENC_ADDRESS   = r_enc_addr;

endmodule

// File: tb/tb_quad_encoder_scheduler.sv
// Directed bench for quad_encoder_scheduler: register tables plus hand-timed round,
// periodic, overrun, EN-clear, optional IRQ and mid-round reset sequences.
module tb_quad_encoder_scheduler;

    localparam int unsigned NENC = 2;
    localparam int unsigned PREC = 32;
    localparam int unsigned AW   = 4;
    localparam int unsigned CW   = 1;

    typedef struct {
        int          addr;
        logic [31:0] exp;
    } vec_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [AW-1:0]   avl_addr = '0;
    logic            avl_read = 1'b0;
    logic            avl_write = 1'b0;
    logic [31:0]     avl_wdata = '0;
    logic [31:0]     avl_rdata;
    logic [CW-1:0]   enc_addr;
    logic            enc_read;
    logic [PREC-1:0] enc_rdata = '0;
`ifdef QUAD_ENCODER_SCHEDULER_IRQ_EN
    logic            irq;
`endif

    logic [31:0] model [NENC];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          enc_pulses = 0;
    int          addr0_q[$];

    quad_encoder_scheduler #(
        .pENCODERS          (NENC),
        .pENCODER_PRECISION (PREC)
    ) dut (
        .iCLK            (clk),
        .iRESET_N        (rst_n),
        .iAVL_ADDRESS    (avl_addr),
        .iAVL_READ       (avl_read),
        .iAVL_WRITE      (avl_write),
        .iAVL_WRITE_DATA (avl_wdata),
        .oAVL_READ_DATA  (avl_rdata),
        .oENC_ADDRESS    (enc_addr),
        .oENC_READ       (enc_read),
        .iENC_READ_DATA  (enc_rdata)
`ifdef QUAD_ENCODER_SCHEDULER_IRQ_EN
        ,
        .oIRQ            (irq)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Counter-block model: data valid the cycle after the read strobe.
    always @(posedge clk) if (enc_read) enc_rdata <= model[enc_addr];

    always @(negedge clk) begin
        if (rst_n && enc_read) begin
            enc_pulses++;
            if (enc_addr == '0) addr0_q.push_back(cyc);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic bus_wr(input int a, input logic [31:0] d);
        avl_addr  = AW'(a);
        avl_wdata = d;
        avl_write = 1'b1;
        @(posedge clk);
        @(negedge clk);
        avl_write = 1'b0;
    endtask

    task automatic bus_rd(input int a, output logic [31:0] d);
        avl_addr = AW'(a);
        avl_read = 1'b1;
        @(posedge clk);
        @(negedge clk);
        avl_read = 1'b0;
        d = avl_rdata;
    endtask

    task automatic wait_pulses(input int n, input int budget);
        int k;
        k = 0;
        while (addr0_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (addr0_q.size() < n) chk("pulse_timeout", 32'(addr0_q.size()), 32'(n));
    endtask

    vec_t        rst_tab [16];
    vec_t        r1_tab  [6];
    vec_t        r2_tab  [5];
    logic [31:0] d;
    int          n0;
    int          n1;
    int          k;
    bit          found;

    initial begin
        for (int i = 0; i < 16; i++) rst_tab[i] = '{i, 32'h0};
        r1_tab[0] = '{8,  32'd100};
        r1_tab[1] = '{10, 32'hFFFF_FFFB};
        r1_tab[2] = '{9,  32'd0};
        r1_tab[3] = '{11, 32'd0};
        r1_tab[4] = '{3,  32'd1};
        r1_tab[5] = '{2,  32'h2};
        r2_tab[0] = '{8,  32'd130};
        r2_tab[1] = '{10, 32'hFFFF_FFF6};
        r2_tab[2] = '{9,  32'd30};
        r2_tab[3] = '{11, 32'hFFFF_FFFB};
        r2_tab[4] = '{3,  32'd2};
        model[0] = '0;
        model[1] = '0;

        // Reset held with random bus activity.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            avl_addr  = AW'($urandom);
            avl_read  = 1'($urandom);
            avl_write = 1'($urandom);
            avl_wdata = $urandom;
        end
        chk("rst_enc_read", 32'(enc_read), 32'd0);
        chk("rst_rdata", avl_rdata, 32'd0);
        @(negedge clk);
        avl_read  = 1'b0;
        avl_write = 1'b0;
        rst_n     = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            bus_rd(rst_tab[i].addr, d);
            chk($sformatf("rst_reg@%0d", rst_tab[i].addr), d, rst_tab[i].exp);
        end

        // First host-triggered round: strobes at cycles 1 and 3, commit at cycle 5.
        model[0] = 32'd100;
        model[1] = 32'hFFFF_FFFB;
        bus_wr(0, 32'h2);
        chk("r1_c1_read", 32'(enc_read), 32'd1);
        chk("r1_c1_addr", 32'(enc_addr), 32'd0);
        @(negedge clk);
        chk("r1_c2_read", 32'(enc_read), 32'd0);
        @(negedge clk);
        chk("r1_c3_read", 32'(enc_read), 32'd1);
        chk("r1_c3_addr", 32'(enc_addr), 32'd1);
        @(negedge clk);
        chk("r1_c4_read", 32'(enc_read), 32'd0);
        @(negedge clk);
        chk("r1_c5_read", 32'(enc_read), 32'd0);
        bus_rd(8, d);
        chk("r1_commit_cycle_old_pos0", d, 32'd0);
        for (int i = 0; i < 6; i++) begin
            bus_rd(r1_tab[i].addr, d);
            chk($sformatf("r1_reg@%0d", r1_tab[i].addr), d, r1_tab[i].exp);
        end

        // Second round produces real deltas.
        model[0] = 32'd130;
        model[1] = 32'hFFFF_FFF6;
        bus_wr(0, 32'h2);
        repeat (5) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            bus_rd(r2_tab[i].addr, d);
            chk($sformatf("r2_reg@%0d", r2_tab[i].addr), d, r2_tab[i].exp);
        end
        bus_wr(2, 32'h2);
        bus_rd(2, d);
        chk("ready_w1c", d, 32'h0);

        // Periodic mode, PERIOD=20; first commit after EN rise has zero delta.
        model[0] = 32'd200;
        bus_wr(1, 32'd20);
        n0 = addr0_q.size();
        bus_wr(0, 32'h1);
        wait_pulses(n0 + 1, 100);
        repeat (6) @(negedge clk);
        bus_rd(9, d);
        chk("en_rise_delta0", d, 32'd0);
        bus_rd(8, d);
        chk("en_rise_pos0", d, 32'd200);
        wait_pulses(n0 + 3, 100);
        chk("period20_gap1", 32'(addr0_q[n0 + 1] - addr0_q[n0]), 32'd20);
        chk("period20_gap2", 32'(addr0_q[n0 + 2] - addr0_q[n0 + 1]), 32'd20);
        bus_rd(2, d);
        chk("period20_no_overrun", 32'(d[2]), 32'd0);

        // PERIOD=3 is shorter than a round: overrun and one commit every 6 cycles.
        bus_wr(1, 32'd3);
        n1 = addr0_q.size();
        wait_pulses(n1 + 4, 200);
        chk("period3_gap1", 32'(addr0_q[n1 + 2] - addr0_q[n1 + 1]), 32'd6);
        chk("period3_gap2", 32'(addr0_q[n1 + 3] - addr0_q[n1 + 2]), 32'd6);
        bus_rd(2, d);
        chk("period3_overrun", 32'(d[2]), 32'd1);

        // Clear EN in the WAIT cycle of channel 0: round finishes, nothing follows.
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if (enc_read && enc_addr == '0) found = 1'b1;
        end
        chk("find_issue_ch0", 32'(found), 32'd1);
        @(negedge clk);
        bus_wr(0, 32'h0);
        repeat (10) @(negedge clk);
        bus_rd(3, d);
        chk("en_clear_round_committed", d, 32'(addr0_q.size()));
        k = enc_pulses;
        repeat (100) @(negedge clk);
        chk("en_clear_no_reads", 32'(enc_pulses), 32'(k));
        bus_wr(2, 32'h6);
        bus_rd(2, d);
        chk("status_w1c_all", d, 32'h0);

`ifdef QUAD_ENCODER_SCHEDULER_IRQ_EN
        bus_wr(0, 32'h6);
        chk("irq_c1", 32'(irq), 32'd0);
        repeat (4) @(negedge clk);
        chk("irq_c5", 32'(irq), 32'd0);
        @(negedge clk);
        chk("irq_c6", 32'(irq), 32'd1);
        bus_wr(2, 32'h2);
        chk("irq_cleared", 32'(irq), 32'd0);
        bus_rd(0, d);
        chk("ctrl_ie_readback", d, 32'h4);
`else
        bus_wr(0, 32'h4);
        bus_rd(0, d);
        chk("ctrl_ie_ignored", d, 32'h0);
`endif

        // Asynchronous reset in the middle of a round.
        bus_wr(0, 32'h2);
        chk("mid_rst_issue", 32'(enc_read), 32'd1);
        #1 rst_n = 1'b0;
        #1 chk("mid_rst_enc_read", 32'(enc_read), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus_rd(8, d);
        chk("mid_rst_pos0", d, 32'd0);
        bus_rd(3, d);
        chk("mid_rst_seq", d, 32'd0);
        bus_rd(2, d);
        chk("mid_rst_status", d, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/quad_encoder_scheduler.md
Name: quad_encoder_scheduler

Overview:
- Sequencer that sits between the host Avalon bus and the quadrature-encoder counter block.
- Periodically, or on host trigger, reads every encoder counter in a round-robin pass through the counter block's Avalon read port.
- Commits all positions atomically to a host-visible snapshot bank, together with the per-channel delta (velocity) since the previous snapshot.
- Lets firmware read a coherent multi-axis position set without racing the free-running counters.

Parameters:
- pENCODERS, 2, number of encoder channels sequenced (1..16).
- pENCODER_PRECISION, 32, counter width returned by the counter block (1..32); zero-extended to 32 on the host side.
- pADDR_W, $clog2(8+2*pENCODERS), host address width (derived).

Ports:
- iCLK  in  1  system clock.
- iRESET_N  in  1  asynchronous active-low reset.
- iAVL_ADDRESS  in  pADDR_W  host slave word address.
- iAVL_READ  in  1  host read strobe.
- iAVL_WRITE  in  1  host write strobe.
- iAVL_WRITE_DATA  in  32  host write data.
- oAVL_READ_DATA  out  32  host read data, valid the cycle after iAVL_READ.
- oENC_ADDRESS  out  $clog2(pENCODERS)  counter-block channel select.
- oENC_READ  out  1  counter-block read strobe.
- iENC_READ_DATA  in  pENCODER_PRECISION  counter value, valid the cycle after oENC_READ.
- oIRQ  out  1  snapshot-ready interrupt (only with the optional feature).

Behaviour:
- Reset: all registers, snapshots and deltas 0; oENC_READ=0; oENC_ADDRESS=0; oAVL_READ_DATA=0; FSM in IDLE; timer=0.
- Register map (word addresses):
  - 0 CTRL: bit0 EN, bit1 TRIG (write-1, self-clearing, reads 0).
  - 1 PERIOD: 32-bit period in clocks.
  - 2 STATUS: bit0 BUSY (RO); bit1 READY (sticky, write-1-clear); bit2 OVERRUN (sticky, write-1-clear).
  - 3 SEQ: 32-bit round counter, wraps.
  - 8+2c POS[c]; 9+2c DELTA[c].
  - Unmapped addresses read 0; writes to them are ignored.
- Host reads: registered, 1-cycle latency, return pre-edge values. A read in the commit cycle returns the old snapshot.
- Timer:
  - When EN=1 and PERIOD!=0, it counts up and fires a trigger when count==PERIOD-1, then restarts at 0.
  - EN=0 or PERIOD=0 holds the timer at 0 and disables periodic triggers.
  - Writing PERIOD restarts the timer at 0.
- FSM states:
  - IDLE: a trigger (timer or TRIG) moves to ISSUE with channel=0.
  - ISSUE: oENC_READ=1 and oENC_ADDRESS=channel for exactly one cycle, then go to WAIT.
  - WAIT: capture iENC_READ_DATA into pending[channel]. If channel==pENCODERS-1 go to COMMIT, else increment channel and go to ISSUE.
  - COMMIT: for every c, DELTA[c]=pending[c]-POS[c] (mod 2^32, two's complement) and POS[c]=pending[c], all in one cycle. SEQ++, READY=1, then go to IDLE.
- Round length is 2*pENCODERS+1 cycles from trigger acceptance to commit. BUSY=1 from ISSUE through COMMIT.
- First commit after reset, or after EN rises from 0: DELTA forced to 0 (no valid previous sample).
- A trigger arriving while not IDLE is dropped and sets OVERRUN. A simultaneous timer trigger and TRIG in IDLE count as one trigger.
- Clearing EN mid-round: the round still completes and commits. Periodic triggers stop after that.
- A write-1-clear on READY in the same cycle as COMMIT: the set wins.
- Async reset mid-round: immediate return to IDLE, oENC_READ deasserts, snapshots cleared.

Optional Feature:
- Macro QUAD_ENCODER_SCHEDULER_IRQ_EN.
- Defined:
  - CTRL bit2 IE.
  - oIRQ=READY&IE, registered from the same edge as READY.
  - Cleared by write-1-clear to READY.
- Undefined: no oIRQ port; CTRL bit2 reads 0 and ignores writes.

Decomposition:
- Package quad_encoder_scheduler_pkg holds:
  - the FSM state enum (IDLE, ISSUE, WAIT, COMMIT);
  - register address localparams (CTRL, PERIOD, STATUS, SEQ, SNAP_BASE=8);
  - CTRL/STATUS bit-position constants.
- Sub-module quad_encoder_scheduler_timer: period counter with EN, PERIOD, restart inputs and a single-cycle fire output.

Test Plan:
- Reset: hold iRESET_N=0 with random bus activity -> every register reads 0, oENC_READ=0.
- Channels 0,1 model values 100 and -5; write CTRL=0x2 -> oENC_READ pulses with addresses 0 then 1 at cycles 1 and 3; commit at cycle 5; POS0=100, POS1=0xFFFFFFFB, DELTA=0, SEQ=1, STATUS=0x2.
- Second TRIG with model values 130 and -10 -> DELTA0=30, DELTA1=0xFFFFFFFB, SEQ=2.
- PERIOD=20, EN=1 -> commits every 20 cycles. PERIOD=3 with pENCODERS=2 -> OVERRUN=1 and a commit every 6 cycles.
- Clear EN during WAIT of channel 0 -> round commits, then no further oENC_READ for 100 cycles.
- With QUAD_ENCODER_SCHEDULER_IRQ_EN and IE=1, TRIG -> oIRQ=1 the cycle READY sets; write STATUS=0x2 -> oIRQ=0 next cycle.
